memory_bus_controller: RTL and testbench
========================================

Name: memory_bus_controller

Overview:
Downstream slave of the multi-cycle RV32I core's memory bus (memory_read, memory_write, option, address, write_data, read_data). It decodes the address into on-chip word-organised RAM and a small MMIO block: LED register, UART TX with FIFO, and a 64-bit cycle counter. It performs byte, halfword and word lane steering and load extension. It is the only memory slave in the SoC top.

Parameters:
MEMORY_WORDS, 1024, RAM depth in 32-bit words (power of two)
CLK_FREQ, 25000000, clk frequency in Hz
BAUD_RATE, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer division
TX_FIFO_DEPTH, 8, UART TX FIFO entries (power of two, at least 2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
memory_read  input  1  read strobe, one cycle per access
memory_write  input  1  write strobe, one cycle per access
option  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
load_unsigned  input  1  1 = zero-extend byte/half loads (funct3[2])
address  input  32  byte address
write_data  input  32  store data, right-aligned
read_data  output  32  load data, registered
leds  output  8  LED register
uart_tx  output  1  serial TX line, 8N1, idle high
misaligned_error  output  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset (synchronous, active-high, clock clk): read_data=0, leds=0, uart_tx=1, misaligned_error=0, FIFO empty, TX FSM IDLE, cycle counter=0, overflow flag=0, shadow=0. RAM contents are not reset.
- Address map:
  - RAM at 0x0000_0000 .. MEMORY_WORDS*4-1. Word index is address[log2(MEMORY_WORDS)+1:2]. RAM does not alias above its range.
  - 0x8000_0000 LED (RW, bits[7:0]).
  - 0x8000_0004 UART data (W pushes byte write_data[7:0]; R returns 0).
  - 0x8000_0008 UART status (RO): bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow. Reading it clears overflow.
  - 0x8000_000C counter low (RO). Reading it also latches counter[63:32] into a shadow.
  - 0x8000_0010 returns the shadow (RO).
  - Unmapped: reads return 0, writes are ignored, no error.
- Read latency: exactly 1 cycle. read_data updates on the clk edge after memory_read and holds until the next read.
- Writes commit on the clk edge where memory_write=1.
- If memory_read and memory_write are both high, the write executes, the read is ignored and read_data holds.
- Alignment: half requires address[0]=0; word requires address[1:0]=0. A misaligned access is dropped: no write, and read_data becomes 0. misaligned_error pulses 1 in the following cycle.
- Stores: byte writes lane address[1:0] with write_data[7:0]. Half writes lanes {address[1],0} with write_data[15:0]. Use per-byte write enables; no read-modify-write.
- Loads: the selected byte or half is shifted to bit 0, then sign-extended (load_unsigned=0) or zero-extended (load_unsigned=1). Sub-word MMIO reads use the same lane rules.
- MMIO registers are written with the full aligned word regardless of size, except UART data, where only byte lane 0 matters.
- UART TX FIFO: circular, with count width log2(TX_FIFO_DEPTH)+1.
  - A push when full is dropped and sets overflow (sticky).
  - A push and a pop in the same cycle are both honoured; count is unchanged.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE.
  - Each state/bit lasts CLKS_PER_BIT cycles.
  - IDLE pops the FIFO head in the cycle the FIFO is non-empty; START begins on the next edge.
  - STOP goes directly to START if the FIFO is non-empty at the end of the stop bit (back-to-back frames).
  - tx_busy = FSM not in IDLE.
- Cycle counter: increments every cycle and wraps at 2^64-1 -> 0.
- Reset mid-frame: uart_tx returns to 1 on the same edge, the FIFO empties and the FSM goes to IDLE; there is no partial-frame completion.

Test Plan:
1. Write word 0xDEADBEEF to 0x10, then read word 0x10 -> read_data=0xDEADBEEF one cycle after the read strobe; read half 0x12 signed -> 0xFFFFDEAD.
2. Byte store 0x7F to 0x21 over word 0x00000000 at 0x20 -> word reads 0x00007F00. Byte 0x80 stored to 0x23, then read back -> signed 0xFFFFFF80, load_unsigned=1 gives 0x00000080.
3. With CLK_FREQ=16, BAUD_RATE=1: write 0x55 to 0x8000_0004 -> uart_tx low for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high; status bit2 is 1 during the frame and 0 after.
4. Push 10 bytes with the FSM busy (depth 8) -> status reads full=1, overflow=1. A second status read gives overflow=0, and exactly 9 frames are transmitted (1 popped early + 8).
5. Half read at 0x13 and word write at 0x22 -> misaligned_error pulses once each, read_data=0, and word 0x20 is unchanged.
6. Assert reset during data bit 3 of a frame -> uart_tx=1 on the next edge, status=0x2, leds=0, and counter low reads a small value after release.

Source files
------------

// File: rtl/memory_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_controller
// Description : Bus slave that decodes word RAM and MMIO (LEDs, UART TX with
//               FIFO, 64-bit cycle counter), steering byte and half lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bus_controller #(
   parameter int MEMORY_WORDS  = 1024,
   parameter int CLK_FREQ      = 25000000,
   parameter int BAUD_RATE     = 115200,
   parameter int TX_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memory_read,
   input  logic        memory_write,
   input  logic [1:0]  option,
   input  logic        load_unsigned,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic [7:0]  leds,
   output logic        uart_tx,
   output logic        misaligned_error
);

   localparam int          c_AW         = $clog2(MEMORY_WORDS);
   localparam int          c_FW         = $clog2(TX_FIFO_DEPTH);
   localparam int          c_CPB_RAW    = CLK_FREQ / BAUD_RATE;
   localparam int          c_CPB        = (c_CPB_RAW < 1) ? 1 : c_CPB_RAW;
   localparam logic [31:0] c_CPB_LAST   = 32'(c_CPB - 1);
   localparam logic [c_FW:0] c_FIFO_FULL = (c_FW + 1)'(TX_FIFO_DEPTH);
   localparam logic [c_FW:0] c_CNT_ONE   = (c_FW + 1)'(1);
   localparam logic [29:0] c_LED_WORD    = 30'h2000_0000;
   localparam logic [29:0] c_UART_WORD   = 30'h2000_0001;
   localparam logic [29:0] c_STATUS_WORD = 30'h2000_0002;
   localparam logic [29:0] c_CNTLO_WORD  = 30'h2000_0003;
   localparam logic [29:0] c_CNTHI_WORD  = 30'h2000_0004;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

   logic [31:0]     r_mem [MEMORY_WORDS];
   logic [7:0]      r_fifo [TX_FIFO_DEPTH];
   logic [31:0]     r_read_data;
   logic [7:0]      r_leds;
   logic            r_uart_tx;
   logic            r_misaligned;
   logic [c_FW-1:0] r_wr_ptr;
   logic [c_FW-1:0] r_rd_ptr;
   logic [c_FW:0]   r_count;
   logic            r_overflow;
   logic [63:0]     r_counter;
   logic [31:0]     r_shadow;
   tx_state_t       r_state;
   logic [31:0]     r_clk_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;

   logic            w_misaligned;
   logic            w_wr;
   logic            w_rd;
   logic            w_ram_hit;
   logic [c_AW-1:0] w_word_idx;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata;
   logic [31:0]     w_rd_word;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [31:0]     w_load_val;
   logic            w_push;
   logic            w_push_ok;
   logic            w_pop;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic            w_tx_busy;
   logic            w_bit_end;

   assign read_data        = r_read_data;
   assign leds             = r_leds;
   assign uart_tx          = r_uart_tx;
   assign misaligned_error = r_misaligned;

   // Size 11 is treated as a word access.
   assign w_misaligned = (option == 2'b01) ? address[0]
                       : (option[1] ? (address[1:0] != 2'b00) : 1'b0);
   assign w_wr       = memory_write && !w_misaligned;
   assign w_rd       = memory_read && !memory_write && !w_misaligned;
   assign w_ram_hit  = (address[31:c_AW+2] == '0);
   assign w_word_idx = address[c_AW+1:2];

   assign w_fifo_full  = (r_count == c_FIFO_FULL);
   assign w_fifo_empty = (r_count == '0);
   assign w_tx_busy    = (r_state != S_IDLE);
   assign w_bit_end    = (r_clk_cnt == c_CPB_LAST);
   assign w_push       = w_wr && !w_ram_hit && (address[31:2] == c_UART_WORD);
   assign w_push_ok    = w_push && !w_fifo_full;
   assign w_pop        = !w_fifo_empty &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = write_data;
      case (option)
         2'b00: begin
            w_be    = 4'b0001 << address[1:0];
            w_wdata = {4{write_data[7:0]}};
         end
         2'b01: begin
            w_be    = address[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{write_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_rd_word = 32'h0;
      if (w_ram_hit) begin
         w_rd_word = r_mem[w_word_idx];
      end else begin
         case (address[31:2])
            c_LED_WORD:    w_rd_word = {24'h0, r_leds};
            c_STATUS_WORD: w_rd_word = {28'h0, r_overflow, w_tx_busy, w_fifo_empty, w_fifo_full};
            c_CNTLO_WORD:  w_rd_word = r_counter[31:0];
            c_CNTHI_WORD:  w_rd_word = r_shadow;
            default:       w_rd_word = 32'h0;
         endcase
      end
   end

   always_comb begin
      case (address[1:0])
         2'b00:   w_byte = w_rd_word[7:0];
         2'b01:   w_byte = w_rd_word[15:8];
         2'b10:   w_byte = w_rd_word[23:16];
         default: w_byte = w_rd_word[31:24];
      endcase
      w_half = address[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      case (option)
         2'b00:   w_load_val = {{24{w_byte[7] & ~load_unsigned}}, w_byte};
         2'b01:   w_load_val = {{16{w_half[15] & ~load_unsigned}}, w_half};
         default: w_load_val = w_rd_word;
      endcase
   end

   // RAM and FIFO storage carry no reset.
   always_ff @(posedge clk) begin
      if (w_wr && w_ram_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_word_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
      if (w_push_ok) r_fifo[r_wr_ptr] <= write_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_read_data  <= 32'h0;
         r_leds       <= 8'h0;
         r_misaligned <= 1'b0;
         r_counter    <= 64'h0;
         r_shadow     <= 32'h0;
         r_overflow   <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         r_counter    <= r_counter + 64'd1;
         r_misaligned <= (memory_read || memory_write) && w_misaligned;
         if (memory_read && !memory_write)
            r_read_data <= w_misaligned ? 32'h0 : w_load_val;
         if (w_wr && !w_ram_hit && (address[31:2] == c_LED_WORD))
            r_leds <= write_data[7:0];
         if (w_rd && !w_ram_hit && (address[31:2] == c_CNTLO_WORD))
            r_shadow <= r_counter[63:32];
         if (w_push && w_fifo_full)
            r_overflow <= 1'b1;
         else if (w_rd && !w_ram_hit && (address[31:2] == c_STATUS_WORD))
            r_overflow <= 1'b0;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= 32'h0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h0;
         r_uart_tx <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_uart_tx <= 1'b1;
               r_clk_cnt <= 32'h0;
               if (w_pop) begin
                  r_shift   <= r_fifo[r_rd_ptr];
                  r_state   <= S_START;
                  r_uart_tx <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_clk_cnt <= 32'h0;
                  r_bit_idx <= 3'd0;
                  r_state   <= S_DATA;
                  r_uart_tx <= r_shift[0];
               end else begin
                  r_clk_cnt <= r_clk_cnt + 32'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= 32'h0;
                  if (r_bit_idx == 3'd7) begin
                     r_state   <= S_STOP;
                     r_uart_tx <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= r_shift >> 1;
                     r_uart_tx <= r_shift[1];
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 32'd1;
               end
            end
            default: begin
               if (w_bit_end) begin
                  r_clk_cnt <= 32'h0;
                  // Back-to-back frame: skip IDLE when more data is queued.
                  if (w_pop) begin
                     r_shift   <= r_fifo[r_rd_ptr];
                     r_state   <= S_START;
                     r_uart_tx <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 32'd1;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bus_controller
// Description : Directed bench for memory_bus_controller (RAM, MMIO, UART TX).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bus_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memory_read = 1'b0;
   logic        memory_write = 1'b0;
   logic [1:0]  option = 2'b10;
   logic        load_unsigned = 1'b0;
   logic [31:0] address = 32'h0;
   logic [31:0] write_data = 32'h0;
   logic [31:0] read_data;
   logic [7:0]  leds;
   logic        uart_tx;
   logic        misaligned_error;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   memory_bus_controller #(
      .MEMORY_WORDS(64), .CLK_FREQ(16), .BAUD_RATE(1), .TX_FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .reset(reset), .memory_read(memory_read), .memory_write(memory_write),
      .option(option), .load_unsigned(load_unsigned), .address(address),
      .write_data(write_data), .read_data(read_data), .leds(leds),
      .uart_tx(uart_tx), .misaligned_error(misaligned_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] opt);
      @(negedge clk);
      address = a; write_data = d; option = opt; memory_write = 1'b1;
      @(posedge clk); #1;
      memory_write = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [1:0] opt, input logic uns,
                          output logic [31:0] d);
      @(negedge clk);
      address = a; option = opt; load_unsigned = uns; memory_read = 1'b1;
      @(posedge clk); #1;
      memory_read = 1'b0;
      d = read_data;
   endtask

   // Decodes one 8N1 frame, sampling mid-bit; got=0 if no start bit appears.
   task automatic rx_frame(output logic got, output logic [7:0] b);
      got = 1'b0;
      b = 8'h0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (uart_tx == 1'b0) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         repeat (8) @(negedge clk);
         for (int k = 0; k < 8; k++) begin
            repeat (16) @(negedge clk);
            b[k] = uart_tx;
         end
         repeat (16) @(negedge clk);
         check("rx_stop_bit", {31'h0, uart_tx}, 32'h1);
      end
   endtask

   logic [31:0] v, v2;
   logic        got;
   logic [7:0]  rb;
   logic        found;
   int          t_start;
   int          frames;
   logic [7:0]  exp_bits;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_read_data", read_data, 32'h0);
      check("reset_leds", {24'h0, leds}, 32'h0);
      check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
      check("reset_misaligned", {31'h0, misaligned_error}, 32'h0);
      reset = 1'b0;
      do_read(32'h8000_0008, 2'b10, 1'b0, v);
      check("status_after_reset", v, 32'h2);

      do_write(32'h10, 32'hDEAD_BEEF, 2'b10);
      do_read(32'h10, 2'b10, 1'b0, v);
      check("word_read_10", v, 32'hDEAD_BEEF);
      do_read(32'h12, 2'b01, 1'b0, v);
      check("half_signed_12", v, 32'hFFFF_DEAD);
      do_read(32'h10, 2'b00, 1'b1, v);
      check("byte_unsigned_10", v, 32'h0000_00EF);

      do_write(32'h20, 32'h0, 2'b10);
      do_write(32'h21, 32'h0000_007F, 2'b00);
      do_read(32'h20, 2'b10, 1'b0, v);
      check("byte_store_21", v, 32'h0000_7F00);
      do_write(32'h23, 32'hFFFF_FF80, 2'b00);
      do_read(32'h23, 2'b00, 1'b0, v);
      check("byte_signed_23", v, 32'hFFFF_FF80);
      do_read(32'h23, 2'b00, 1'b1, v);
      check("byte_unsigned_23", v, 32'h0000_0080);
      do_write(32'h42, 32'hAAAA_1234, 2'b01);
      do_read(32'h40, 2'b10, 1'b0, v);
      check("half_store_42", v[31:16], 32'h1234);

      do_read(32'h13, 2'b01, 1'b0, v);
      check("misaligned_read_data", v, 32'h0);
      check("misaligned_read_pulse", {31'h0, misaligned_error}, 32'h1);
      @(posedge clk); #1;
      check("misaligned_pulse_ends", {31'h0, misaligned_error}, 32'h0);
      do_write(32'h22, 32'hFFFF_FFFF, 2'b10);
      check("misaligned_write_pulse", {31'h0, misaligned_error}, 32'h1);
      do_read(32'h20, 2'b10, 1'b0, v);
      check("misaligned_write_dropped", v, 32'h8000_7F00);

      // Simultaneous read and write: write lands, read_data holds.
      do_read(32'h10, 2'b10, 1'b0, v);
      @(negedge clk);
      address = 32'h44; write_data = 32'h1234_5678; option = 2'b10;
      memory_read = 1'b1; memory_write = 1'b1;
      @(posedge clk); #1;
      memory_read = 1'b0; memory_write = 1'b0;
      check("rw_read_holds", read_data, 32'hDEAD_BEEF);
      do_read(32'h44, 2'b10, 1'b0, v);
      check("rw_write_done", v, 32'h1234_5678);

      do_write(32'h0, 32'h1111_1111, 2'b10);
      do_write(32'h100, 32'h2222_2222, 2'b10);
      do_read(32'h0, 2'b10, 1'b0, v);
      check("ram_no_alias", v, 32'h1111_1111);
      do_read(32'h100, 2'b10, 1'b0, v);
      check("above_ram_reads_0", v, 32'h0);
      do_read(32'h4000_0000, 2'b10, 1'b0, v);
      check("unmapped_reads_0", v, 32'h0);
      do_write(32'h8000_0000, 32'h0000_01A5, 2'b10);
      check("led_write", {24'h0, leds}, 32'hA5);
      do_read(32'h8000_0000, 2'b00, 1'b1, v);
      check("led_byte_read", v, 32'hA5);

      do_read(32'h8000_000C, 2'b10, 1'b0, v);
      do_read(32'h8000_000C, 2'b10, 1'b0, v2);
      check("counter_step", v2 - v, 32'h1);
      do_read(32'h8000_0010, 2'b10, 1'b0, v);
      check("counter_shadow", v, 32'h0);

      // Single frame 0x55 with boundary checks around the start bit.
      do_write(32'h8000_0004, 32'h0000_0055, 2'b00);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (uart_tx == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check("start_bit_seen", {31'h0, found}, 32'h1);
      repeat (15) @(negedge clk);
      check("start_bit_last_cycle", {31'h0, uart_tx}, 32'h0);
      @(negedge clk);
      check("bit0_first_cycle", {31'h0, uart_tx}, 32'h1);
      repeat (7) @(negedge clk);
      check("bit0_mid", {31'h0, uart_tx}, 32'h1);
      do_read(32'h8000_0008, 2'b10, 1'b0, v);
      check("status_busy", v, 32'h6);
      exp_bits = 8'h55;
      repeat (15) @(negedge clk);
      for (int k = 1; k < 8; k++) begin
         check($sformatf("bit%0d_mid", k), {31'h0, uart_tx}, {31'h0, exp_bits[k]});
         repeat (16) @(negedge clk);
      end
      check("stop_mid", {31'h0, uart_tx}, 32'h1);
      repeat (16) @(negedge clk);
      do_read(32'h8000_0008, 2'b10, 1'b0, v);
      check("status_idle_after_frame", v, 32'h2);

      // Ten pushes: first pops at once, eight fill the FIFO, last overflows.
      for (int i = 1; i <= 10; i++) begin
         do_write(32'h8000_0004, 32'(i), 2'b00);
         if (i == 2) t_start = cyc;
      end
      do_read(32'h8000_0008, 2'b10, 1'b0, v);
      check("status_full_overflow", v, 32'hD);
      do_read(32'h8000_0008, 2'b10, 1'b0, v);
      check("status_overflow_cleared", v, 32'h5);
      check("first_frame_started", {31'h0, uart_tx}, 32'h0);
      frames = 1;
      while (cyc < t_start + 150) @(negedge clk);
      for (int i = 2; i <= 10; i++) begin
         rx_frame(got, rb);
         if (got) begin
            frames++;
            check($sformatf("rx_byte_%0d", i), {24'h0, rb}, 32'(i));
         end
         else break;
      end
      check("frames_sent", 32'(frames), 32'd9);

      // Reset in the middle of data bit 3 of 0xA5.
      do_write(32'h8000_0000, 32'h0000_003C, 2'b10);
      do_write(32'h8000_0004, 32'h0000_00A5, 2'b00);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (uart_tx == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check("a5_start_seen", {31'h0, found}, 32'h1);
      repeat (72) @(negedge clk);
      check("a5_bit3_mid", {31'h0, uart_tx}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("reset_uart_tx_high", {31'h0, uart_tx}, 32'h1);
      check("reset_leds_clear", {24'h0, leds}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      do_read(32'h8000_0008, 2'b10, 1'b0, v);
      check("status_after_midframe_reset", v, 32'h2);
      do_read(32'h8000_000C, 2'b10, 1'b0, v);
      check("counter_small_after_reset", {31'h0, v < 32'd8}, 32'h1);
      repeat (40) @(negedge clk);
      check("line_idle_after_reset", {31'h0, uart_tx}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
